// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer for the SIMPLE core: fetch, operand read,
// execute, memory/branch, writeback, with memory wait timeout, halt and flags.
module phase_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir_in,
  input  logic        s_in,
  input  logic        z_in,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        mem_ready,
  output logic [2:0]  phase,
  output logic        ir_e,
  output logic        ar_e,
  output logic        br_e,
  output logic        dr_e,
  output logic        mdr_e,
  output logic        reg_e,
  output logic        pc_e,
  output logic        pc_sel,
  output logic        wb_sel,
  output logic        mem_e,
  output logic        mem_w,
  output logic [3:0]  flags,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  wait_cnt;

  logic is_alu, is_cmp, is_hlt, is_ld, is_st, is_li, is_b, is_bcc;
  logic wb_class, flags_load, cond_true, take_branch, sv;
  logic ir_low_unused;

  assign ir_low_unused = ^ir[3:0];

  assign is_alu     = (ir[15:14] == 2'b11);
  assign is_cmp     = is_alu && (ir[7:4] == 4'b0101);
  assign is_hlt     = is_alu && (ir[7:4] == 4'b1111);
  assign is_ld      = (ir[15:14] == 2'b00);
  assign is_st      = (ir[15:14] == 2'b01);
  assign is_li      = (ir[15:14] == 2'b10) && (ir[13:11] == 3'b000);
  assign is_b       = (ir[15:14] == 2'b10) && (ir[13:11] == 3'b100);
  assign is_bcc     = (ir[15:14] == 2'b10) && (ir[13:11] == 3'b111);
  assign wb_class   = (is_alu && !is_cmp && !is_hlt) || is_li || is_ld;
  assign flags_load = is_alu && !is_hlt;

  // Branch conditions use the registered flags {S,Z,C,V} from the last ALU/CMP.
  assign sv = flags[3] ^ flags[0];
  always_comb begin
    cond_true = 1'b0;
    case (ir[10:8])
      3'b000:  cond_true = flags[2];
      3'b001:  cond_true = sv;
      3'b010:  cond_true = flags[2] | sv;
      3'b011:  cond_true = !flags[2];
      default: cond_true = 1'b0;
    endcase
  end
  assign take_branch = is_b || (is_bcc && cond_true);

  // Sequencing, IR capture, flag register and memory wait timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= 16'h0000;
      wait_cnt <= 8'd0;
      flags    <= 4'b0000;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            state    <= S_P1;
            wait_cnt <= 8'd0;
          end
        end
        S_P1: begin
          if (mem_ready) begin
            ir    <= ir_in;
            state <= S_P2;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_P2: state <= S_P3;
        S_P3: begin
          if (flags_load) flags <= {s_in, z_in, c_in, v_in};
          wait_cnt <= 8'd0;
          state    <= S_P4;
        end
        S_P4: begin
          if (is_ld || is_st) begin
            if (mem_ready) begin
              state <= S_P5;
            end else if (wait_cnt == WAIT_LAST) begin
              state <= S_ERR;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            state <= S_P5;
          end
        end
        S_P5: begin
          wait_cnt <= 8'd0;
          state    <= is_hlt ? S_HALT : S_P1;
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_ERR;
      endcase
    end
  end

  always_comb begin
    ir_e   = 1'b0;
    ar_e   = 1'b0;
    br_e   = 1'b0;
    dr_e   = 1'b0;
    mdr_e  = 1'b0;
    reg_e  = 1'b0;
    pc_e   = 1'b0;
    pc_sel = 1'b0;
    wb_sel = 1'b0;
    mem_e  = 1'b0;
    mem_w  = 1'b0;
    case (state)
      S_P1: begin
        mem_e = 1'b1;
        ir_e  = mem_ready;
        pc_e  = mem_ready;
      end
      S_P2: begin
        ar_e = 1'b1;
        br_e = 1'b1;
      end
      S_P3: dr_e = 1'b1;
      S_P4: begin
        if (is_ld) begin
          mem_e = 1'b1;
          mdr_e = mem_ready;
        end else if (is_st) begin
          mem_e = 1'b1;
          mem_w = 1'b1;
        end else if (take_branch) begin
          pc_e   = 1'b1;
          pc_sel = 1'b1;
        end
      end
      S_P5: begin
        reg_e  = wb_class;
        wb_sel = is_ld;
      end
      default: ;
    endcase
  end

  assign phase  = state;
  assign halted = (state == S_HALT);
  assign err    = (state == S_ERR);

endmodule
